// File: rtl/serial_mmio_bridge.sv
// serial_mmio_bridge: bus-mapped RX/TX byte FIFOs with STATUS/CTRL registers.
// Define SERIAL_IRQ_EN to add the irq_out port and the CTRL[4:3] IRQ enables.
module serial_mmio_bridge #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        addr_in,
    input  logic              rd_en_in,
    input  logic              wr_en_in,
    input  logic [31:0]       wr_data_in,
    output logic [31:0]       rd_data_out,
    input  logic [DATA_W-1:0] serial_in,
    input  logic              serial_valid_in,
    output logic              serial_rden_out,
    output logic [DATA_W-1:0] serial_out,
    input  logic              serial_ready_in,
    output logic              serial_wren_out
`ifdef SERIAL_IRQ_EN
    ,
    output logic              irq_out
`endif
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
    logic [RX_AW-1:0]  r_rx_wptr;
    logic [RX_AW-1:0]  r_rx_rptr;
    logic [RX_CW-1:0]  r_rx_count;
    logic [TX_AW-1:0]  r_tx_wptr;
    logic [TX_AW-1:0]  r_tx_rptr;
    logic [TX_CW-1:0]  r_tx_count;
    logic              r_tx_ovf;
    logic              r_rx_udf;
    logic [31:0]       r_rd_data;
    logic [DATA_W-1:0] r_serial_out;
    logic              r_serial_wren;
    logic              r_rx_irq_en;
    logic              r_tx_irq_en;

    logic              w_sel_data;
    logic              w_sel_ctrl;
    logic              w_rd_data;
    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_flush;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_tx_push;
    logic              w_tx_drain;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [31:0]       w_status;
    logic [31:0]       w_ctrl;
    logic [31:0]       w_rd_val;
    logic              w_unused;

    assign w_sel_data = (addr_in == 2'd0);
    assign w_sel_ctrl = (addr_in == 2'd2);
    assign w_rd_data  = rd_en_in & w_sel_data;
    assign w_wr_data  = wr_en_in & w_sel_data;
    assign w_wr_ctrl  = wr_en_in & w_sel_ctrl;
    assign w_flush    = w_wr_ctrl & wr_data_in[2];

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == RX_CW'(RX_DEPTH));
    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == TX_CW'(TX_DEPTH));

    // A flush still acknowledges the serial byte, but the byte is dropped.
    assign serial_rden_out = reset & serial_valid_in & ~w_rx_full;
    assign w_rx_push  = serial_rden_out & ~w_flush;
    assign w_rx_pop   = w_rd_data & ~w_rx_empty & ~w_flush;
    assign w_udf_set  = w_rd_data & w_rx_empty;
    assign w_tx_push  = w_wr_data & ~w_tx_full;
    assign w_ovf_set  = w_wr_data & w_tx_full;
    assign w_tx_drain = ~w_tx_empty & serial_ready_in & ~w_flush;

    assign w_unused = ^wr_data_in;

    assign rd_data_out     = r_rd_data;
    assign serial_out      = r_serial_out;
    assign serial_wren_out = r_serial_wren;

    always_ff @(posedge clock) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= serial_in;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= wr_data_in[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else if (w_flush) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + RX_AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + RX_CW'(1);
                2'b01:   r_rx_count <= r_rx_count - RX_CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else if (w_flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + TX_AW'(1);
            end
            if (w_tx_drain) begin
                r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            end
            case ({w_tx_push, w_tx_drain})
                2'b10:   r_tx_count <= r_tx_count + TX_CW'(1);
                2'b01:   r_tx_count <= r_tx_count - TX_CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_serial_out  <= '0;
            r_serial_wren <= 1'b0;
        end else begin
            r_serial_wren <= w_tx_drain;
            if (w_tx_drain) begin
                r_serial_out <= r_tx_mem[r_tx_rptr];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            r_tx_ovf <= w_ovf_set | (r_tx_ovf & ~(w_wr_ctrl & wr_data_in[0]));
            r_rx_udf <= w_udf_set | (r_rx_udf & ~(w_wr_ctrl & wr_data_in[1]));
        end
    end

`ifdef SERIAL_IRQ_EN
    logic r_irq;

    assign irq_out = r_irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_rx_irq_en <= wr_data_in[3];
                r_tx_irq_en <= wr_data_in[4];
            end
            r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty)
                   | r_tx_ovf | r_rx_udf;
        end
    end
`else
    assign r_rx_irq_en = 1'b0;
    assign r_tx_irq_en = 1'b0;
`endif

    always_comb begin
        w_status        = '0;
        w_status[0]     = w_rx_empty;
        w_status[1]     = w_rx_full;
        w_status[2]     = w_tx_empty;
        w_status[3]     = w_tx_full;
        w_status[4]     = r_tx_ovf;
        w_status[5]     = r_rx_udf;
        w_status[15:8]  = 8'(r_rx_count);
        w_status[23:16] = 8'(r_tx_count);
    end

    always_comb begin
        w_ctrl    = '0;
        w_ctrl[3] = r_rx_irq_en;
        w_ctrl[4] = r_tx_irq_en;
    end

    always_comb begin
        w_rd_val = '0;
        case (addr_in)
            2'd0: begin
                if (!w_rx_empty) begin
                    w_rd_val = 32'(r_rx_mem[r_rx_rptr]);
                end
            end
            2'd1:    w_rd_val = w_status;
            2'd2:    w_rd_val = w_ctrl;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (rd_en_in) begin
            r_rd_data <= w_rd_val;
        end
    end

endmodule
